// File: rtl/xpar_uart.sv
// xpar_uart: 8N1 UART on the picoVersat parallel bus. It has a small TX FIFO,
// a single-entry RX holding register and a software-programmable baud divisor.
//
// state | meaning
// IDLE  | TX: waiting for FIFO data      / RX: waiting for a synchronized low
// START | TX: driving the start bit      / RX: waiting to re-check the line mid-bit
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | TX: driving the stop bit       / RX: waiting to sample the stop bit
module xpar_uart #(
    parameter int          DATA_W     = 32,
    parameter int          PAR_ADDR_W = 12,
    parameter int          TX_DEPTH   = 4,
    parameter logic [15:0] DIV_RST    = 16'd433
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PAR_ADDR_W-1:0] par_addr,
    input  logic                  par_re,
    input  logic                  par_we,
    input  logic [DATA_W-1:0]     par_out,
    output logic [DATA_W-1:0]     par_in,
    output logic                  txd,
    input  logic                  rxd
);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [15:0]      div_q, div_d;
    logic [7:0]       fifo_q [TX_DEPTH];
    logic [7:0]       fifo_d [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    logic        rx_s1_q, rx_s2_q;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;

    logic [1:0] addr;
    logic       wr_tx, wr_stat, wr_div, rd_pop;
    logic       tx_full, tx_empty, tx_busy, tx_push, tx_pop, rx_done;
    logic       unused_bits;

    assign addr     = par_addr[1:0];
    assign wr_tx    = par_we && (addr == 2'd0);
    assign wr_stat  = par_we && (addr == 2'd1);
    assign wr_div   = par_we && (addr == 2'd3);
    assign rd_pop   = par_re && (addr == 2'd2) && rx_valid_q;
    assign tx_full  = (count_q == CNT_W'(TX_DEPTH));
    assign tx_empty = (count_q == '0);
    assign tx_busy  = (tx_state_q != S_IDLE);
    assign tx_push  = wr_tx && !tx_full;
    assign txd      = txd_q;
    assign unused_bits = ^{par_out[DATA_W-1:16], par_addr[PAR_ADDR_W-1:2]};

    // Bit timers reload div_q at every bit boundary, so a DIV write lands on the next bit.
    always_comb begin
        div_d      = wr_div ? par_out[15:0] : div_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;

        case (tx_state_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_q[rd_ptr_q];
                    tx_state_d = S_START;
                    tx_cnt_d   = div_q;
                end
            end
            S_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = div_q;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_shift_d = {1'b1, tx_shift_q[7:1]};
                    tx_cnt_d   = div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (tx_cnt_q == 16'd0) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_q[rd_ptr_q];
                        tx_state_d = S_START;
                        tx_cnt_d   = div_q;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
        endcase

        if (tx_push) begin
            fifo_d[wr_ptr_q] = par_out[7:0];
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({tx_push, tx_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Registered line driven from the next state keeps txd glitch-free.
        case (tx_state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done     = 1'b0;

        case (rx_state_q)
            S_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = {1'b0, div_q[15:1]};
                end
            end
            S_START: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                    rx_cnt_d   = div_q;
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = div_q;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_done    = 1'b1;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
        endcase
    end

    // Flag sets are applied after the software clears so a same-edge event wins.
    always_comb begin
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = rd_pop ? 1'b0 : rx_valid_q;
        overrun_d   = (wr_stat && par_out[4]) ? 1'b0 : overrun_q;
        frame_err_d = (wr_stat && par_out[5]) ? 1'b0 : frame_err_q;
        if (rx_done) begin
            if (rx_valid_q && !rd_pop) begin
                overrun_d = 1'b1;
            end else begin
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end
            if (!rx_s2_q) begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        par_in = '0;
        if (par_re) begin
            case (addr)
                2'd1:    par_in[5:0]  = {frame_err_q, overrun_q, rx_valid_q,
                                         tx_busy, tx_empty, tx_full};
                2'd2:    par_in[7:0]  = rx_byte_q;
                2'd3:    par_in[15:0] = div_q;
                default: par_in       = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= DIV_RST;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            txd_q       <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            txd_q       <= txd_d;
            rx_s1_q     <= rxd;
            rx_s2_q     <= rx_s1_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end
endmodule

// File: tb/tb_xpar_uart.sv
// Bench for xpar_uart: checks bus reads, TX waveforms and RX loopback against
// a bit-timing model of an 8N1 frame.
module tb_xpar_uart;
    localparam int DATA_W     = 32;
    localparam int PAR_ADDR_W = 12;
    localparam logic [31:0] DIV_RST = 32'd433;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PAR_ADDR_W-1:0] par_addr;
    logic                  par_re, par_we;
    logic [DATA_W-1:0]     par_out, par_in;
    logic                  txd, rxd, rxd_drv, loopback;

    int   checks = 0;
    int   errors = 0;
    logic rec_en = 1'b0;
    logic rec_q [$];

    assign rxd = loopback ? txd : rxd_drv;
    always #5 clk = ~clk;
    always @(negedge clk) if (rec_en) rec_q.push_back(txd);

    xpar_uart dut (
        .clk      (clk),
        .rst      (rst),
        .par_addr (par_addr),
        .par_re   (par_re),
        .par_we   (par_we),
        .par_out  (par_out),
        .par_in   (par_in),
        .txd      (txd),
        .rxd      (rxd)
    );

    // Line level k cycles into a frame carrying b with bit period d+1.
    function automatic logic model_txd(input logic [7:0] b, input int k, input int d);
        int pos;
        pos = k / (d + 1);
        if (pos == 0) return 1'b0;
        if (pos >= 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        par_addr = PAR_ADDR_W'({$urandom(), a});
        par_out  = v;
        par_we   = 1'b1;
        @(posedge clk);
        #1 par_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        par_addr = PAR_ADDR_W'({$urandom(), a});
        par_re   = 1'b1;
        #1 v = par_in;
        @(posedge clk);
        #1 par_re = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1; par_re = 1'b0; par_we = 1'b0; par_addr = '0; par_out = '0;
        rxd_drv = 1'b1; loopback = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (par_in !== 32'h0) begin errors++; $display("FAIL reset_par_in got %h want 0", par_in); end
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
        cpu_read(2'd1, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL reset_status got %h want 2", v); end
        cpu_read(2'd3, v);
        checks++;
        if (v !== DIV_RST) begin errors++; $display("FAIL reset_div got %0d want %0d", v, DIV_RST); end
    endtask

    task automatic test_tx_frame(input logic [7:0] b, input int d);
        int   frame;
        logic exp;
        frame = 10 * (d + 1);
        cpu_write(2'd3, 32'(d));
        cpu_write(2'd0, {24'h0, b});
        par_addr = PAR_ADDR_W'(1);
        par_re   = 1'b1;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || par_in[2] !== 1'b0) begin
            errors++; $display("FAIL tx_pre txd=%b busy=%b want 1/0", txd, par_in[2]);
        end
        for (int k = 0; k < frame; k++) begin
            @(negedge clk);
            exp = model_txd(b, k, d);
            checks++;
            if (txd !== exp || par_in[2] !== 1'b1) begin
                errors++;
                $display("FAIL tx_frame byte=%h div=%0d k=%0d txd=%b busy=%b want %b/1", b, d, k, txd, par_in[2], exp);
            end
        end
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || par_in[2:0] !== 3'b010) begin
            errors++; $display("FAIL tx_post txd=%b status=%b want 1/010", txd, par_in[2:0]);
        end
        par_re = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [6];
        logic [31:0] v;
        int          mism;
        cpu_write(2'd3, 32'd3);
        for (int i = 0; i < 6; i++) begin
            bytes[i] = 8'($urandom());
            cpu_write(2'd0, {24'h0, bytes[i]});
            if (i == 0) begin rec_q.delete(); rec_en = 1'b1; end
        end
        cpu_read(2'd1, v);
        checks++;
        if (v[2:0] !== 3'b101) begin errors++; $display("FAIL b2b_full status=%b want 101", v[2:0]); end
        repeat (210) @(negedge clk);
        rec_en = 1'b0;
        checks++;
        if (rec_q.size() < 206) begin
            errors++; $display("FAIL b2b_record size=%0d want >=206", rec_q.size());
        end else begin
            checks++;
            if (rec_q[0] !== 1'b1) begin errors++; $display("FAIL b2b_lead txd=%b want 1", rec_q[0]); end
            for (int f = 0; f < 5; f++) begin
                mism = -1;
                for (int k = 0; k < 40; k++)
                    if (mism < 0 && rec_q[1 + f*40 + k] !== model_txd(bytes[f], k, 3)) mism = k;
                checks++;
                if (mism >= 0) begin
                    errors++;
                    $display("FAIL b2b_frame%0d byte=%h cycle=%0d txd=%b want %b", f, bytes[f], mism,
                             rec_q[1 + f*40 + mism], model_txd(bytes[f], mism, 3));
                end
            end
            mism = -1;
            for (int k = 201; k < 206; k++) if (mism < 0 && rec_q[k] !== 1'b1) mism = k;
            checks++;
            if (mism >= 0) begin errors++; $display("FAIL b2b_sixth_dropped cycle=%0d txd=0 want 1", mism); end
        end
        cpu_read(2'd1, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL b2b_drained status=%h want 2", v); end
    endtask

    task automatic test_loopback(input logic [7:0] b);
        logic [31:0] v;
        int          seen;
        loopback = 1'b1;
        cpu_write(2'd3, 32'd7);
        cpu_write(2'd0, {24'h0, b});
        seen = -1;
        for (int i = 0; i < 200 && seen < 0; i++) begin
            cpu_read(2'd1, v);
            if (v[3]) seen = i;
        end
        checks++;
        if (seen < 0) begin
            errors++; $display("FAIL loop_rx_valid timeout got 0 want 1");
        end else begin
            checks++;
            if (seen < 72 || seen > 84) begin errors++; $display("FAIL loop_latency got %0d want 72..84", seen); end
            checks++;
            if (v[5:4] !== 2'b00) begin errors++; $display("FAIL loop_flags got %b want 00", v[5:4]); end
            cpu_read(2'd2, v);
            checks++;
            if (v !== {24'h0, b}) begin errors++; $display("FAIL loop_rxdata got %h want %h", v, b); end
            cpu_read(2'd1, v);
            checks++;
            if (v[3] !== 1'b0) begin errors++; $display("FAIL loop_pop rx_valid=%b want 0", v[3]); end
        end
        repeat (20) @(negedge clk);
        loopback = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0]  a, b;
        logic [31:0] v;
        a = 8'($urandom()); b = 8'($urandom());
        loopback = 1'b1;
        cpu_write(2'd3, 32'd7);
        cpu_write(2'd0, {24'h0, a});
        cpu_write(2'd0, {24'h0, b});
        repeat (200) @(negedge clk);
        cpu_read(2'd1, v);
        checks++;
        if (v !== 32'h1A) begin errors++; $display("FAIL ovr_status got %h want 1a", v); end
        cpu_read(2'd2, v);
        checks++;
        if (v !== {24'h0, a}) begin errors++; $display("FAIL ovr_keeps_old got %h want %h", v, a); end
        cpu_write(2'd1, 32'h10);
        cpu_read(2'd1, v);
        checks++;
        if (v !== 32'h02) begin errors++; $display("FAIL ovr_clear got %h want 2", v); end
        loopback = 1'b0;
    endtask

    task automatic test_frame_err();
        logic [7:0]  b;
        logic [9:0]  bits;
        logic [31:0] v;
        b    = 8'($urandom());
        bits = {1'b0, b, 1'b0};
        cpu_write(2'd3, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd_drv = bits[i];
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        rxd_drv = 1'b1;
        repeat (30) @(negedge clk);
        cpu_read(2'd1, v);
        checks++;
        if (v !== 32'h2A) begin errors++; $display("FAIL ferr_status got %h want 2a", v); end
        cpu_read(2'd2, v);
        checks++;
        if (v !== {24'h0, b}) begin errors++; $display("FAIL ferr_rxdata got %h want %h", v, b); end
        cpu_write(2'd1, 32'h20);
        cpu_read(2'd1, v);
        checks++;
        if (v !== 32'h02) begin errors++; $display("FAIL ferr_clear got %h want 2", v); end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        int          len;
        len = int'($urandom_range(1, 2));
        cpu_write(2'd3, 32'd7);
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (len) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (100) @(negedge clk);
        cpu_read(2'd1, v);
        checks++;
        if (v !== 32'h02) begin errors++; $display("FAIL glitch len=%0d status=%h want 2", len, v); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        int          zeros;
        cpu_write(2'd3, 32'd3);
        cpu_write(2'd0, {24'h0, 8'($urandom())});
        cpu_write(2'd0, {24'h0, 8'($urandom())});
        repeat (12) @(negedge clk);
        cpu_read(2'd1, v);
        checks++;
        if (v[2] !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", v[2]); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        par_addr = PAR_ADDR_W'(1);
        par_re   = 1'b1;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || par_in !== 32'h02) begin
            errors++; $display("FAIL rstmid_state txd=%b status=%h want 1/2", txd, par_in);
        end
        par_re = 1'b0;
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) zeros++;
        end
        checks++;
        if (zeros != 0) begin errors++; $display("FAIL rstmid_fifo_lost low_cycles=%0d want 0", zeros); end
        cpu_read(2'd3, v);
        checks++;
        if (v !== DIV_RST) begin errors++; $display("FAIL rstmid_div got %0d want %0d", v, DIV_RST); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_frame(8'hA5, 3);
        test_tx_frame(8'($urandom()), int'($urandom_range(3, 6)));
        test_tx_frame(8'($urandom()), int'($urandom_range(3, 6)));
        test_back_to_back();
        test_loopback(8'h3C);
        test_loopback(8'($urandom()));
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
